// File: rtl/aes256_pkg.sv
// Shared widths and FSM state encoding for the AES-256 load sequencer.
package aes256_pkg;
  localparam int AES_KEY_W     = 256;
  localparam int AES_BLK_W     = 128;
  localparam int AES_BYTE_W    = 8;
  localparam int AES_NUM_BYTES = 16;

  typedef enum logic [2:0] {
    IDLE,
    KEY_START,
    KEY_WAIT,
    READY,
    REQ,
    WAIT_BYTE,
    OUT_HOLD,
    ERR
  } ctrl_state_t;

  // States in which the controller will accept a new key.
  function automatic logic key_accept_state(ctrl_state_t s);
    return (s == IDLE) || (s == READY) || (s == ERR);
  endfunction
endpackage

// File: rtl/aes256_load_ctrl_if.sv
// Host-side key / plaintext / ciphertext ready-valid bundle.
interface aes256_load_ctrl_if;
  import aes256_pkg::*;

  logic                 key_valid;
  logic                 key_ready;
  logic [AES_KEY_W-1:0] key_in;
  logic                 blk_in_valid;
  logic                 blk_in_ready;
  logic [AES_BLK_W-1:0] blk_in;
  logic                 blk_out_valid;
  logic                 blk_out_ready;
  logic [AES_BLK_W-1:0] blk_out;

  modport master (
    output key_valid, key_in, blk_in_valid, blk_in, blk_out_ready,
    input  key_ready, blk_in_ready, blk_out_valid, blk_out
  );

  modport slave (
    input  key_valid, key_in, blk_in_valid, blk_in, blk_out_ready,
    output key_ready, blk_in_ready, blk_out_valid, blk_out
  );
endinterface

// File: rtl/aes256_byte_collector.sv
// Byte counter plus per-slot assembly register; byte 0 lands in the top byte.
// word already reflects the byte being loaded this cycle, so the final word can be captured on the last load.
module aes256_byte_collector
  import aes256_pkg::*;
#(
  parameter int NUM_BYTES = AES_NUM_BYTES
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear,
  input  logic                            load_byte,
  input  logic [AES_BYTE_W-1:0]           byte_in,
  output logic                            done,
  output logic [NUM_BYTES*AES_BYTE_W-1:0] word
);
  localparam int CNT_W = $clog2(NUM_BYTES);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cnt_reg <= '0;
    else if (clear)     cnt_reg <= '0;
    else if (load_byte) cnt_reg <= cnt_reg + 1'b1;
  end

  assign done = (cnt_reg == CNT_W'(NUM_BYTES - 1));

  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_slot
    logic [AES_BYTE_W-1:0] slot_reg;
    logic                  hit;

    assign hit = load_byte && (cnt_reg == CNT_W'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   slot_reg <= '0;
      else if (hit) slot_reg <= byte_in;
    end

    assign word[(NUM_BYTES-1-gi)*AES_BYTE_W +: AES_BYTE_W] = hit ? byte_in : slot_reg;
  end
endmodule

// File: rtl/aes256_load_ctrl.sv
// Sequencer for the byte-serial AES-256 core: key expansion, 16 byte requests per block,
// ciphertext assembly, and a response watchdog that parks the FSM in ERR.
module aes256_load_ctrl
  import aes256_pkg::*;
#(
  parameter int NUM_BYTES   = 16,
  parameter int TIMEOUT_CYC = 1024,
  parameter int TO_W        = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  aes256_load_ctrl_if.slave     host,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  core_key_expand_start,
  output logic [AES_KEY_W-1:0]  core_master_key,
  input  logic                  core_key_ready,
  output logic                  core_next_val_req,
  output logic [AES_BLK_W-1:0]  core_data_in,
  input  logic                  core_next_val_ready,
  input  logic [AES_BYTE_W-1:0] core_data_out
);
  ctrl_state_t          state_reg, state_next;
  logic [TO_W-1:0]      wd_reg;
  logic                 key_ready_reg, blk_in_ready_reg, blk_out_valid_reg;
  logic                 busy_reg, err_reg, start_reg, req_reg;
  logic [AES_BLK_W-1:0] blk_out_reg, data_in_reg;
  logic [AES_KEY_W-1:0] key_reg;
  logic                 key_fire, blk_fire, byte_fire, wd_expired;
  logic                 col_done;
  logic [AES_BLK_W-1:0] col_word;

  // A pending key offer masks the block handshake so the key always wins.
  assign host.blk_in_ready = blk_in_ready_reg && !host.key_valid;
  assign key_fire   = host.key_valid && key_ready_reg;
  assign blk_fire   = host.blk_in_valid && host.blk_in_ready;
  assign byte_fire  = (state_reg == WAIT_BYTE) && core_next_val_ready;
  assign wd_expired = (wd_reg == TO_W'(TIMEOUT_CYC));

  aes256_byte_collector #(.NUM_BYTES(NUM_BYTES)) u_collector (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (blk_fire),
    .load_byte (byte_fire),
    .byte_in   (core_data_out),
    .done      (col_done),
    .word      (col_word)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, ERR: if (key_fire) state_next = KEY_START;
      KEY_START: state_next = KEY_WAIT;
      KEY_WAIT: begin
        if (core_key_ready)  state_next = READY;
        else if (wd_expired) state_next = ERR;
      end
      READY: begin
        if (key_fire)      state_next = KEY_START;
        else if (blk_fire) state_next = REQ;
      end
      REQ: state_next = WAIT_BYTE;
      WAIT_BYTE: begin
        if (core_next_val_ready) state_next = col_done ? OUT_HOLD : REQ;
        else if (wd_expired)     state_next = ERR;
      end
      OUT_HOLD: if (host.blk_out_ready) state_next = READY;
      default: state_next = IDLE;
    endcase
  end

  // Every output is registered from the destination state so it lines up with state_reg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      wd_reg            <= '0;
      key_ready_reg     <= 1'b0;
      blk_in_ready_reg  <= 1'b0;
      blk_out_valid_reg <= 1'b0;
      busy_reg          <= 1'b0;
      err_reg           <= 1'b0;
      start_reg         <= 1'b0;
      req_reg           <= 1'b0;
      blk_out_reg       <= '0;
      data_in_reg       <= '0;
      key_reg           <= '0;
    end else begin
      state_reg         <= state_next;
      key_ready_reg     <= key_accept_state(state_next);
      blk_in_ready_reg  <= (state_next == READY);
      blk_out_valid_reg <= (state_next == OUT_HOLD);
      busy_reg          <= !key_accept_state(state_next);
      start_reg         <= (state_next == KEY_START);
      req_reg           <= (state_next == REQ);

      if (state_next != state_reg)
        wd_reg <= '0;
      else if (((state_reg == KEY_WAIT) || (state_reg == WAIT_BYTE)) && !wd_expired)
        wd_reg <= wd_reg + 1'b1;

      if (key_fire) begin
        key_reg <= host.key_in;
        err_reg <= 1'b0;
      end else if ((state_next == ERR) && (state_reg != ERR)) begin
        err_reg <= 1'b1;
      end

      if (blk_fire) data_in_reg <= host.blk_in;
      if (byte_fire && col_done) blk_out_reg <= col_word;
    end
  end

  assign host.key_ready     = key_ready_reg;
  assign host.blk_out_valid = blk_out_valid_reg;
  assign host.blk_out       = blk_out_reg;
  assign busy                  = busy_reg;
  assign timeout_err           = err_reg;
  assign core_key_expand_start = start_reg;
  assign core_next_val_req     = req_reg;
  assign core_master_key       = key_reg;
  assign core_data_in          = data_in_reg;
endmodule
